// File: rtl/systolic_host_port.sv
// Host port for the 4x4 int8 systolic MAC: streams A rows / B columns out as
// 64-bit beats, gathers 64-bit result beats into a 512-bit result, with a watchdog.
module systolic_host_port #(
  parameter int unsigned BEATS_IN    = 4,
  parameter int unsigned BEATS_OUT   = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] a_mat,
  input  logic [127:0] b_mat,
  output logic         valid_in,
  output logic [63:0]  data_out,
  output logic         src_valid,
  input  logic         dest_ready,
  input  logic [63:0]  final_data_in,
  input  logic         dest_valid,
  output logic         src_ready,
  input  logic         done_matrix_mult,
  output logic [511:0] result,
  output logic         result_valid,
  output logic         busy,
  output logic         error
);

  localparam int unsigned IN_W  = (BEATS_IN  > 1) ? $clog2(BEATS_IN)  : 1;
  localparam int unsigned OUT_W = (BEATS_OUT > 1) ? $clog2(BEATS_OUT) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {IDLE, REQ, SEND, COLLECT, WAIT_DONE} state_t;

  state_t           state, state_next;
  logic [127:0]     a_reg, b_reg;
  logic [IN_W-1:0]  in_cnt;
  logic [OUT_W-1:0] out_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [63:0]      beat;
  logic             in_xfer, out_xfer, last_in, last_out, timed_out;
  logic             accept, finish, abort;

  always_comb begin
    src_valid = (state == REQ) || (state == SEND);
    valid_in  = (state == REQ);
    src_ready = (state == COLLECT);
    busy      = (state != IDLE);
    in_xfer   = src_valid && dest_ready;
    out_xfer  = src_ready && dest_valid;
    last_in   = (in_cnt == IN_W'(BEATS_IN - 1));
    last_out  = (out_cnt == OUT_W'(BEATS_OUT - 1));
    timed_out = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    accept    = (state == IDLE) && start;
  end

  // Beat k carries A row k (upper word) and B column k (lower word).
  always_comb begin
    beat = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (in_cnt == IN_W'(k)) begin
        for (int unsigned c = 0; c < 4; c++)
          beat[63-8*c -: 8] = a_reg[127-8*(4*k+c) -: 8];
        for (int unsigned r = 0; r < 4; r++)
          beat[31-8*r -: 8] = b_reg[127-8*(4*r+k) -: 8];
      end
    end
    data_out = src_valid ? beat : '0;
  end

  // A handshake in the same cycle as the watchdog expiring counts as progress.
  always_comb begin
    state_next = state;
    finish     = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: if (start) state_next = REQ;
      REQ: begin
        if (in_xfer)        state_next = last_in ? COLLECT : SEND;
        else if (timed_out) abort = 1'b1;
      end
      SEND: begin
        if (in_xfer) begin
          if (last_in) state_next = COLLECT;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      COLLECT: begin
        if (out_xfer) begin
          if (last_out) begin
            if (done_matrix_mult) begin
              finish     = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = WAIT_DONE;
            end
          end
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done_matrix_mult) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (timed_out) begin
          abort = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      to_cnt       <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= finish;

      if (accept) begin
        a_reg  <= a_mat;
        b_reg  <= b_mat;
        in_cnt <= '0;
        error  <= 1'b0;
      end else if (abort) begin
        error <= 1'b1;
      end

      if (in_xfer) begin
        in_cnt <= last_in ? '0 : in_cnt + 1'b1;
        if (last_in) out_cnt <= '0;
      end

      if (out_xfer) begin
        out_cnt <= out_cnt + 1'b1;
        for (int unsigned i = 0; i < BEATS_OUT; i++)
          if (out_cnt == OUT_W'(i)) result[511-64*i -: 64] <= final_data_in;
      end

      if (state_next != state || in_xfer || out_xfer) to_cnt <= '0;
      else if (state != IDLE)                          to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_host_port.sv
// Self-checking bench: the bench plays the systolic array, using a matrix-multiply
// reference model to supply result beats and predict every host-port output.
module tb_systolic_host_port;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] a_mat, b_mat;
  logic         valid_in;
  logic [63:0]  data_out;
  logic         src_valid;
  logic         dest_ready;
  logic [63:0]  final_data_in;
  logic         dest_valid;
  logic         src_ready;
  logic         done_matrix_mult;
  logic [511:0] result;
  logic         result_valid;
  logic         busy;
  logic         error;

  int total = 0;
  int bad   = 0;
  logic [511:0] prev_result = '0;

  systolic_host_port #(
    .BEATS_IN   (4),
    .BEATS_OUT  (8),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .a_mat           (a_mat),
    .b_mat           (b_mat),
    .valid_in        (valid_in),
    .data_out        (data_out),
    .src_valid       (src_valid),
    .dest_ready      (dest_ready),
    .final_data_in   (final_data_in),
    .dest_valid      (dest_valid),
    .src_ready       (src_ready),
    .done_matrix_mult(done_matrix_mult),
    .result          (result),
    .result_valid    (result_valid),
    .busy            (busy),
    .error           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] elem(input logic [127:0] m, input int r, input int c);
    return m[127-8*(4*r+c) -: 8];
  endfunction

  // Reference product C = A*B on signed int8, results as 32-bit signed.
  function automatic logic [511:0] golden(input logic [127:0] a, input logic [127:0] b);
    logic [511:0] y;
    int acc;
    y = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc += int'($signed(elem(a, i, k))) * int'($signed(elem(b, k, j)));
        y[511-32*(4*i+j) -: 32] = acc;
      end
    return y;
  endfunction

  function automatic logic [63:0] beat_of(input logic [127:0] a, input logic [127:0] b, input int k);
    logic [63:0] d;
    for (int c = 0; c < 4; c++) d[63-8*c -: 8] = elem(a, k, c);
    for (int r = 0; r < 4; r++) d[31-8*r -: 8] = elem(b, r, k);
    return d;
  endfunction

  task automatic run_job(input logic [127:0] a, input logic [127:0] b, input bit gaps,
                         input bit disturb, input bit done_last, input bit abort);
    logic [511:0] exp_res;
    logic [63:0]  exp_beat;
    int gap;
    exp_res = golden(a, b);
    @(negedge clk);
    a_mat = a; b_mat = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_b("busy_after_start", busy, 1'b1);
    check_b("error_cleared", error, 1'b0);
    for (int k = 0; k < 4; k++) begin
      exp_beat = beat_of(a, b, k);
      if (disturb && k == 2) begin
        start = 1'b1; a_mat = ~a; b_mat = ~b;
      end
      gap = gaps ? int'($urandom_range(0, 5)) : 0;
      for (int g = 0; g < gap; g++) begin
        dest_ready = 1'b0;
        dest_valid = 1'($urandom_range(0, 1));
        final_data_in = {$urandom, $urandom};
        check_b("src_valid_stall", src_valid, 1'b1);
        check_w("data_out_stall", 512'(data_out), 512'(exp_beat));
        @(negedge clk);
        start = 1'b0;
      end
      dest_valid = 1'b0;
      dest_ready = 1'b1;
      check_b("src_valid", src_valid, 1'b1);
      check_b("valid_in", valid_in, k == 0);
      check_w("data_out", 512'(data_out), 512'(exp_beat));
      @(negedge clk);
      dest_ready = 1'b0; start = 1'b0;
    end
    check_b("src_valid_low", src_valid, 1'b0);
    check_b("src_ready_collect", src_ready, 1'b1);
    check_w("result_hold", result, prev_result);
    for (int m = 0; m < 8; m++) begin
      gap = gaps ? int'($urandom_range(0, 5)) : 0;
      for (int g = 0; g < gap; g++) begin
        dest_valid = 1'b0;
        final_data_in = {$urandom, $urandom};
        check_b("src_ready_stall", src_ready, 1'b1);
        @(negedge clk);
      end
      if (abort && m == 3) begin
        #2 reset = 1'b1;
        #1;
        check_b("abort_busy", busy, 1'b0);
        check_b("abort_src_ready", src_ready, 1'b0);
        check_b("abort_src_valid", src_valid, 1'b0);
        check_b("abort_valid_in", valid_in, 1'b0);
        check_b("abort_result_valid", result_valid, 1'b0);
        check_b("abort_error", error, 1'b0);
        check_w("abort_data_out", 512'(data_out), '0);
        check_w("abort_result", result, '0);
        @(negedge clk);
        reset = 1'b0;
        prev_result = '0;
        return;
      end
      dest_valid = 1'b1;
      final_data_in = exp_res[511-64*m -: 64];
      done_matrix_mult = done_last && (m == 7);
      check_b("result_valid_early", result_valid, 1'b0);
      @(negedge clk);
      dest_valid = 1'b0; done_matrix_mult = 1'b0;
    end
    if (!done_last) begin
      check_b("src_ready_wait", src_ready, 1'b0);
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        check_b("busy_wait", busy, 1'b1);
        check_b("result_valid_wait", result_valid, 1'b0);
        @(negedge clk);
      end
      done_matrix_mult = 1'b1;
      @(negedge clk);
      done_matrix_mult = 1'b0;
    end
    check_b("result_valid_pulse", result_valid, 1'b1);
    check_w("result", result, exp_res);
    check_b("busy_end", busy, 1'b0);
    @(negedge clk);
    check_b("result_valid_once", result_valid, 1'b0);
    check_w("result_after", result, exp_res);
    prev_result = exp_res;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a_mat = '0; b_mat = '0;
    dest_ready = 1'b0; dest_valid = 1'b0; final_data_in = '0; done_matrix_mult = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_error", error, 1'b0);
    check_b("rst_valid_in", valid_in, 1'b0);
    check_b("rst_src_valid", src_valid, 1'b0);
    check_b("rst_src_ready", src_ready, 1'b0);
    check_b("rst_result_valid", result_valid, 1'b0);
    check_w("rst_result", result, '0);
    reset = 1'b0;

    // Identity times sequential B; beat 0 must read 0x01000000_0105090D.
    run_job(128'h01000000_00010000_00000100_00000001,
            128'h01020304_05060708_090A0B0C_0D0E0F10, 1'b0, 1'b0, 1'b0, 1'b0);
    check_w("identity_beat0", 512'(beat_of(128'h01000000_00010000_00000100_00000001,
            128'h01020304_05060708_090A0B0C_0D0E0F10, 0)), 512'(64'h01000000_0105090D));
    run_job('1, '1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_w("all_ff_result", result, {16{32'h00000004}});

    for (int j = 0; j < 4; j++)
      run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);

    run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            1'b1, 1'b1, 1'b0, 1'b0);

    // Watchdog: dest_ready never rises, so REQ must time out 16 cycles after entry.
    @(negedge clk);
    a_mat = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_b("to_busy", busy, 1'b1);
      check_b("to_error_low", error, 1'b0);
      @(negedge clk);
    end
    check_b("to_error", error, 1'b1);
    check_b("to_busy_low", busy, 1'b0);
    check_b("to_src_valid", src_valid, 1'b0);
    check_b("to_valid_in", valid_in, 1'b0);
    check_b("to_result_valid", result_valid, 1'b0);
    check_w("to_result_hold", result, prev_result);

    run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            1'b1, 1'b0, 1'b0, 1'b1);
    run_job({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            1'b1, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_host_port.md
Name: systolic_host_port

Overview:
- Host-side counterpart of the 4x4 int8 systolic MAC top.
- Transmit side: takes 4x4 matrices A and B as parallel words and streams them to the array as four 64-bit beats over the src_valid/dest_ready handshake.
- Receive side: collects the eight 64-bit result beats over the dest_valid/src_ready handshake into a 512-bit result, then waits for the array's completion pulse.
- Watchdog flags a stalled transaction.

Parameters:
BEATS_IN, 4, input beats per job (one A row plus one B column per beat)
BEATS_OUT, 8, result beats per job (two 32-bit results per beat)
TIMEOUT_CYC, 1024, max cycles without a handshake or completion before error

Ports:
clk  in  1  clock
reset  in  1  reset
start  in  1  launch job; sampled in IDLE only
a_mat  in  128  A, row-major; a[r][c] at bits [127-8*(4r+c) -: 8]
b_mat  in  128  B, row-major, same packing
valid_in  out  1  job request to array
data_out  out  64  input beat to array
src_valid  out  1  data_out valid
dest_ready  in  1  array accepts data_out
final_data_in  in  64  result beat from array
dest_valid  in  1  final_data_in valid
src_ready  out  1  host accepts result beat
done_matrix_mult  in  1  array completion pulse
result  out  512  y[0][0] at [511:480] ... y[3][3] at [31:0], 32-bit signed each
result_valid  out  1  one-cycle pulse: result complete
busy  out  1  high in any state except IDLE
error  out  1  sticky timeout flag; cleared by next accepted start

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
- Reset values: all outputs 0, FSM in IDLE, beat and timeout counters 0.
- Reset mid-job aborts immediately; no partial result_valid is produced.
- Handshakes:
  - Input beat transfers on a clk edge with src_valid && dest_ready.
  - Output beat transfers on a clk edge with dest_valid && src_ready.
  - data_out is stable while src_valid=1 and no transfer has occurred.
- Input beat k (0..3): data_out[63:32] = A row k, a[k][0] in [63:56] to a[k][3] in [39:32]; data_out[31:0] = B column k, b[0][k] in [31:24] to b[3][k] in [7:0].
- a_mat and b_mat are registered on the start-accept edge; later changes have no effect on the job.
- FSM states:
  - IDLE: busy=0. start=1 -> capture matrices, clear error, in_cnt=0, go REQ.
  - REQ: valid_in=1 and src_valid=1 with beat 0. Transfer -> in_cnt=1, go SEND.
  - SEND: valid_in=0, src_valid=1 with beat in_cnt. Each transfer increments in_cnt. Transfer with in_cnt=BEATS_IN-1 -> src_valid drops next cycle, out_cnt=0, go COLLECT.
  - COLLECT: src_ready=1. Each transfer writes final_data_in into result[511-64*out_cnt -: 64] and increments out_cnt. Transfer with out_cnt=BEATS_OUT-1 -> go WAIT_DONE.
  - WAIT_DONE: src_ready=0. done_matrix_mult=1 -> result_valid=1 for exactly one cycle, go IDLE. A done_matrix_mult pulse that arrives in the same cycle as the final COLLECT transfer is also honoured.
- Latency: result_valid rises one cycle after done_matrix_mult is observed in WAIT_DONE.
- result holds its value until a new job's first result beat is written.
- Timeout:
  - Counter clears on any handshake and on each state change, and increments every cycle in REQ, SEND, COLLECT and WAIT_DONE.
  - On reaching TIMEOUT_CYC-1: error=1, all handshake outputs drop, go IDLE, no result_valid.
- Ignored stimuli:
  - start while busy is ignored.
  - dest_valid outside COLLECT is ignored; src_ready=0 there.
  - dest_ready outside REQ/SEND has no effect.

Test Plan:
- A=identity, B[r][c]=4r+c+1: start -> 4 input beats; beat0 = 0x01000000_0105090D; result rows = B values, sign-extended to 32 bits; result_valid pulses once after done_matrix_mult.
- A and B all 0xFF (-1): result every word 0x00000004; beat0 = 0xFFFFFFFF_FFFFFFFF.
- Random dest_ready/dest_valid gaps of 0-5 cycles -> data_out stable during stalls; exactly 4 input and 8 output transfers; result matches the golden model.
- dest_ready never asserted with TIMEOUT_CYC=16 -> error=1 sixteen cycles after REQ entry, busy=0, no result_valid; next start clears error.
- start pulsed during SEND, and a_mat changed during SEND -> no effect on beats or result.
- Reset asserted mid-COLLECT after 3 beats -> all outputs 0 immediately; a fresh job then completes correctly.
